// File: rtl/cpu_pkg.sv
// Constants shared by the multicycle datapath and its control FSM.
// The extension-mode encoding must stay in step with the FSM's decode table.
package cpu_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_BRANCH = 2'd2,
        EXT_UPPER  = 2'd3
    } ext_mode_t;

    localparam int EXT_MODE_W = 2;

endpackage

// File: rtl/ext_stage.sv
// One pipeline slot: a valid bit plus a payload register that loads only on en_i.
// The slot stays full until drain_i, unless en_i refills it in the same cycle.
module ext_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         drain_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q;

    assign valid_d = en_i | (valid_q & ~drain_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (en_i) data_q <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: S1 widens the immediate, S2 applies the
// branch shift or upper placement. Valid/ready on both sides.
module imm_extend_pipe
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int PAD_W = OUT_W - IN_W;
    localparam int PL_W  = OUT_W + EXT_MODE_W;

    generate
        if (IN_W < 2) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W must be >= 2");
        end
        if (OUT_W < IN_W + 2) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be >= IN_W + 2");
        end
    endgenerate

    logic             s1_valid, s2_valid;
    logic [PL_W-1:0]  s1_d, s1_q, s2_d, s2_q;
    logic             in_fire, out_fire, s2_load;
    ext_mode_t        in_mode_e, s1_mode_e;
    logic [OUT_W-1:0] s1_ext, s1_data, s2_data;

    assign out_fire = s2_valid & out_ready;
    assign s2_load  = s1_valid & (~s2_valid | out_fire);
    // Ready never looks at in_valid, so no combinational loop with the producer.
    assign in_ready = ~s1_valid | s2_load;
    assign in_fire  = in_valid & in_ready;

    assign in_mode_e = ext_mode_t'(in_mode);

    always_comb begin
        s1_ext = {{PAD_W{1'b0}}, in_imm};
        case (in_mode_e)
            EXT_SIGN, EXT_BRANCH: s1_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
            default:              s1_ext = {{PAD_W{1'b0}}, in_imm};
        endcase
    end

    assign s1_d = {in_mode, s1_ext};

    ext_stage #(.W(PL_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (in_fire),
        .drain_i (s2_load),
        .d_i     (s1_d),
        .valid_o (s1_valid),
        .q_o     (s1_q)
    );

    assign s1_mode_e = ext_mode_t'(s1_q[PL_W-1 -: EXT_MODE_W]);
    assign s1_data   = s1_q[OUT_W-1:0];

    // UPPER kept the raw immediate in the low bits of S1; move it to the top here.
    always_comb begin
        s2_data = s1_data;
        case (s1_mode_e)
            EXT_BRANCH: s2_data = s1_data << 2;
            EXT_UPPER:  s2_data = {s1_data[IN_W-1:0], {PAD_W{1'b0}}};
            default:    s2_data = s1_data;
        endcase
    end

    assign s2_d = {s1_q[PL_W-1 -: EXT_MODE_W], s2_data};

    ext_stage #(.W(PL_W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (s2_load),
        .drain_i (out_fire),
        .d_i     (s2_d),
        .valid_o (s2_valid),
        .q_o     (s2_q)
    );

    assign out_valid = s2_valid;
    assign out_data  = s2_q[OUT_W-1:0];
    assign out_mode  = s2_q[PL_W-1 -: EXT_MODE_W];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default 16->32 instance plus a 12->32 instance.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, out_mode;
    logic [31:0] out_data;

    logic        b_valid, b_ready, b_out_valid;
    logic [11:0] b_imm;
    logic [1:0]  b_mode, b_out_mode;
    logic [31:0] b_out_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        int          c;
    } exp_t;
    exp_t sb[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready), .in_imm(b_imm), .in_mode(b_mode),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .out_mode(b_out_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] imm, input logic [1:0] m);
        case (m)
            2'd0:    return {16'h0000, imm};
            2'd1:    return {{16{imm[15]}}, imm};
            2'd2:    return {{14{imm[15]}}, imm, 2'b00};
            default: return {imm, 16'h0000};
        endcase
    endfunction

    // Monitor: compare on output transfer, record on input transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_mode", out_mode, e.m);
                if (lat_chk) chk("sb_lat", cyc - e.c, 2);
            end
        end
        if (rst_n && in_valid && in_ready)
            sb.push_back('{ref16(in_imm, in_mode), in_mode, cyc});
    end

    task automatic send(input logic [15:0] imm, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_imm = imm; in_mode = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_tmo", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        b_valid = 1'b0; b_imm = '0; b_mode = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        #9 rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed values, back-to-back, full throughput with exact latency.
        out_ready = 1'b1; lat_chk = 1'b1;
        send(16'h8001, 2'd1);
        send(16'h7FFF, 2'd1);
        send(16'hFFFF, 2'd0);
        send(16'h1234, 2'd3);
        send(16'hFFFE, 2'd2);
        send(16'h4000, 2'd2);
        for (int i = 0; i < 8; i++) send(16'($urandom), 2'(i));
        drain();

        // Backpressure: S2 then S1 fill, ready drops, held data stays put.
        lat_chk = 1'b0; out_ready = 1'b0;
        send(16'h8001, 2'd1);
        send(16'h7FFF, 2'd1);
        in_valid = 1'b1; in_imm = 16'hC0DE; in_mode = 2'd1;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 32'hFFFF8001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'hC0DE, 2'd1);
        send(16'h0042, 2'd1);
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(16'hAAAA, 2'd0);
        send(16'h5555, 2'd3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_mode", out_mode, 0);
        sb.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1 chk("post_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1; lat_chk = 1'b1;
        send(16'h1357, 2'd0);
        drain();

        // 12-bit immediate instance.
        b_valid = 1'b1; b_imm = 12'h800; b_mode = 2'd1;
        @(posedge clk); #1;
        b_imm = 12'hABC; b_mode = 2'd3;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        chk("w12_sign_valid", b_out_valid, 1);
        chk("w12_sign_data", b_out_data, 32'hFFFFF800);
        chk("w12_sign_mode", b_out_mode, 1);
        @(negedge clk);
        chk("w12_upper_valid", b_out_valid, 1);
        chk("w12_upper_data", b_out_data, 32'hABC00000);
        chk("w12_upper_mode", b_out_mode, 3);
        @(negedge clk);
        chk("w12_empty", b_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the multicycle CPU datapath. It takes an IN_W-bit immediate and produces an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, sign-extend with shift-left-2 for branch offsets, and upper-load. It carries a valid/ready handshake, so it can sit between the instruction register and the ALU-B operand mux and absorb stalls from the control FSM.

## Interface
Parameters:
- IN_W, default 16: immediate input width; must be ≥ 2.
- OUT_W, default 32: output width; must be ≥ IN_W + 2.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  `in_imm` and `in_mode` are presented.
- in_ready  output  1  stage 1 can accept this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 0 ZERO, 1 SIGN, 2 BRANCH, 3 UPPER.
- out_valid  output  1  `out_data` holds a result.
- out_ready  input  1  consumer accepts `out_data` this cycle.
- out_data  output  OUT_W  extended operand.
- out_mode  output  2  mode that produced `out_data`, for the consumer's debug and assertions.

## Operation
- Input transfer when `in_valid && in_ready`. Output transfer when `out_valid && out_ready`.
- Stage 1 (S1) registers the width extension:
  - ZERO: `{(OUT_W-IN_W) zeros, in_imm}`.
  - SIGN and BRANCH: `in_imm[IN_W-1]` replicated into bits OUT_W-1..IN_W.
  - UPPER: S1 stores `in_imm` unchanged.
  - S1 also registers the mode.
- Stage 2 (S2) registers the final value:
  - ZERO and SIGN: pass the S1 value through.
  - BRANCH: S1 value << 2, zero fill; the top 2 bits are dropped.
  - UPPER: `{in_imm, (OUT_W-IN_W) zeros}`.
- Each stage has one valid bit.
  - S2 loads when S1 is valid and (S2 is empty or S2 transfers out this cycle).
  - `in_ready` = !s1_valid || s2 loads this cycle. Full throughput, no bubbles.
- Backpressure: while `out_ready` is 0, S2 holds. S1 fills, then `in_ready` drops. Held data must not change.
- Simultaneous input and output transfer in the same cycle: both occur; occupancy is unchanged.
- Data registers load only on their stage's enable. Valid bits alone gate visibility.

## Timing
- Latency 2 cycles: a transfer in cycle N gives `out_valid` = 1 in cycle N+2 when not stalled.
- Throughput 1 per cycle.
- `in_ready` is combinational from `out_ready` and the valid bits only, never from `in_valid`.
- `out_valid`, `out_data` and `out_mode` are registered outputs.
- Reset, asynchronous while `rst_n` = 0:
  - s1_valid = s2_valid = 0, so `out_valid` = 0.
  - `out_data` = 0 and `out_mode` = 0.
  - `in_ready` = 1 after reset deasserts.
- Reset mid-operation discards all in-flight entries. No output transfer occurs in the reset cycle.
- Undefined `in_mode` values cannot exist (2 bits fully decoded).

## Structure
- Shared package `cpu_pkg` holds the mode enum `ext_mode_t` (EXT_ZERO=0, EXT_SIGN=1, EXT_BRANCH=2, EXT_UPPER=3). The multicycle control FSM uses the same constants.
- One sub-module, `ext_stage`: a generic valid/data pipeline register with enable, instantiated twice.
- The extension and shift logic is inline in the top.
- Elaboration check: fail if OUT_W < IN_W + 2.

## Test plan
- SIGN, IN_W=16, OUT_W=32: `in_imm` = 0x8001 -> `out_data` = 0xFFFF8001 two cycles later. `in_imm` = 0x7FFF -> 0x00007FFF.
- ZERO and UPPER: `in_imm` = 0xFFFF, ZERO -> 0x0000FFFF. UPPER with 0x1234 -> 0x12340000. `out_mode` matches each.
- BRANCH: `in_imm` = 0xFFFE -> 0xFFFFFFF8. 0x4000 -> 0x00010000.
- Backpressure: stream 4 SIGN values with `out_ready` = 0.
  - `in_ready` falls after 2 accepts.
  - Raising `out_ready` drains all 4 in order, unchanged, with no loss or duplication.
- Full throughput: `out_ready` held at 1, back-to-back inputs -> one output per cycle, exact 2-cycle latency.
- Reset mid-stream: assert `rst_n` = 0 with both stages full.
  - Immediately: `out_valid` = 0 and `out_data` = 0.
  - After release, `in_ready` = 1 and the first new input appears 2 cycles later.
- Parameter sweep: IN_W=12, OUT_W=32 -> SIGN of 0x800 gives 0xFFFFF800. UPPER of 0xABC gives 0xABC00000.
